// File: rtl/qspi_target_pkg.sv
// Shared types and constants for the QSPI target: FSM states, opcodes and nibble helpers.
package qspi_target_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_IGNORE,
      ST_STATUS
   } state_e;

   localparam logic [7:0] OP_QREAD  = 8'h6B;
   localparam logic [7:0] OP_QWRITE = 8'h32;
   localparam logic [7:0] OP_RDSR   = 8'h05;

   localparam int unsigned NIB_PER_BYTE = 2;

   function automatic logic [3:0] byte_nibble(input logic [7:0] b, input logic lo_nib);
      return lo_nib ? b[3:0] : b[7:4];
   endfunction

endpackage

// File: rtl/qspi_sync_edge.sv
// Multi-flop synchronizer for a single asynchronous line with one-cycle rise/fall pulses.
module qspi_sync_edge
   import qspi_target_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic h_clk,
   input  logic h_rstn,
   input  logic d_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   dly_q, dly_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
      dly_d  = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign rise =  sync_q[SYNC_STAGES-1] & ~dly_q;
   assign fall = ~sync_q[SYNC_STAGES-1] &  dly_q;

endmodule

// File: rtl/qspi_target.sv
// QSPI mode-0 target: oversampled SCLK/CS_n/IO, single-line cmd/addr, quad-width data.
// Define QSPI_TARGET_STATUS_EN to accept opcode 0x05 (read status) with sticky status bits.
module qspi_target
   import qspi_target_pkg::*;
#(
   parameter int unsigned ADDR_W      = 24,
   parameter int unsigned DUMMY_CYC   = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              h_clk,
   input  logic              h_rstn,
   input  logic              sclk_in,
   input  logic              cs_n_in,
   input  logic [3:0]        io_in,
   output logic [3:0]        io_out,
   output logic [3:0]        io_oe,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              cmd_err
);

   localparam int unsigned SH_W    = (ADDR_W > 8) ? ADDR_W : 8;
   localparam int unsigned CNT_MAX = (SH_W > DUMMY_CYC) ? SH_W : DUMMY_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   qspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .h_clk(h_clk), .h_rstn(h_rstn), .d_in(sclk_in), .rise(sclk_rise), .fall(sclk_fall));

   qspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .h_clk(h_clk), .h_rstn(h_rstn), .d_in(cs_n_in), .rise(cs_rise), .fall(cs_fall));

   logic [SYNC_STAGES-1:0][3:0] io_sync_q, io_sync_d;
   logic [3:0]                  io_s;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [SH_W-1:0]   shift_q, shift_d, shift_next;
   logic              is_wr_q, is_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        tx_q, tx_d;
   logic              nib_q, nib_d, last_nib;
   logic [3:0]        wr_hi_q, wr_hi_d;
   logic              rd_lat_q, rd_lat_d;
   logic [3:0]        io_out_q, io_out_d, io_oe_q, io_oe_d;
   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, cmd_err_q, cmd_err_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
`ifdef QSPI_TARGET_STATUS_EN
   logic              wr_sticky_q, wr_sticky_d, err_sticky_q, err_sticky_d;
   logic [2:0]        stat_idx_q, stat_idx_d;
   logic [7:0]        status_byte;
   assign status_byte = {6'b0, err_sticky_q, wr_sticky_q};
`endif

   assign io_s       = io_sync_q[SYNC_STAGES-1];
   assign shift_next = {shift_q[SH_W-2:0], io_s[0]};
   assign last_nib   = (32'(nib_q) == NIB_PER_BYTE - 1);

   always_comb begin
      io_sync_d   = {io_sync_q[SYNC_STAGES-2:0], io_in};
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      is_wr_d     = is_wr_q;
      addr_d      = addr_q;
      tx_d        = tx_q;
      nib_d       = nib_q;
      wr_hi_d     = wr_hi_q;
      io_out_d    = io_out_q;
      io_oe_d     = io_oe_q;
      mem_req_d   = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cmd_err_d   = 1'b0;
      // Read data lands one cycle after the memory samples the request.
      rd_lat_d    = mem_req_q & ~mem_we_q;
      if (rd_lat_q) tx_d = mem_rdata;
`ifdef QSPI_TARGET_STATUS_EN
      wr_sticky_d  = wr_sticky_q | (mem_req_q & mem_we_q);
      err_sticky_d = err_sticky_q | cmd_err_q;
      stat_idx_d   = stat_idx_q;
`endif
      if (cs_rise) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         nib_d     = 1'b0;
         io_oe_d   = '0;
         io_out_d  = '0;
         rd_lat_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (cs_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = '0;
            end
            ST_CMD: if (sclk_rise) begin
               shift_d   = shift_next;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(7)) begin
                  bit_cnt_d = '0;
                  if (shift_next[7:0] == OP_QREAD || shift_next[7:0] == OP_QWRITE) begin
                     state_d = ST_ADDR;
                     is_wr_d = (shift_next[7:0] == OP_QWRITE);
                  end
`ifdef QSPI_TARGET_STATUS_EN
                  else if (shift_next[7:0] == OP_RDSR) begin
                     state_d    = ST_STATUS;
                     stat_idx_d = '0;
                  end
`endif
                  else begin
                     cmd_err_d = 1'b1;
                     state_d   = ST_IGNORE;
                  end
               end
            end
            ST_ADDR: if (sclk_rise) begin
               shift_d   = shift_next;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                  bit_cnt_d = '0;
                  addr_d    = shift_next[ADDR_W-1:0];
                  nib_d     = 1'b0;
                  state_d   = is_wr_q ? ST_WR_DATA : ST_DUMMY;
               end
            end
            ST_DUMMY: if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
                  bit_cnt_d  = '0;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = addr_q;
                  state_d    = ST_RD_DATA;
               end
            end
            ST_RD_DATA: if (sclk_fall) begin
               io_oe_d  = '1;
               io_out_d = byte_nibble(tx_q, nib_q);
               nib_d    = ~last_nib;
               if (last_nib) begin
                  addr_d     = addr_q + ADDR_W'(1);
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = addr_q + ADDR_W'(1);
               end
            end
            ST_WR_DATA: if (sclk_rise) begin
               nib_d = ~last_nib;
               if (!last_nib) begin
                  wr_hi_d = io_s;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = addr_q;
                  mem_wdata_d = {wr_hi_q, io_s};
                  addr_d      = addr_q + ADDR_W'(1);
               end
            end
            ST_STATUS: begin
`ifdef QSPI_TARGET_STATUS_EN
               if (sclk_fall) begin
                  io_oe_d    = 4'b0010;
                  io_out_d   = {2'b00, status_byte[3'd7 - stat_idx_q], 1'b0};
                  stat_idx_d = stat_idx_q + 3'd1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         io_sync_q   <= '0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         is_wr_q     <= 1'b0;
         addr_q      <= '0;
         tx_q        <= '0;
         nib_q       <= 1'b0;
         wr_hi_q     <= '0;
         rd_lat_q    <= 1'b0;
         io_out_q    <= '0;
         io_oe_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cmd_err_q   <= 1'b0;
`ifdef QSPI_TARGET_STATUS_EN
         wr_sticky_q  <= 1'b0;
         err_sticky_q <= 1'b0;
         stat_idx_q   <= '0;
`endif
      end else begin
         io_sync_q   <= io_sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         is_wr_q     <= is_wr_d;
         addr_q      <= addr_d;
         tx_q        <= tx_d;
         nib_q       <= nib_d;
         wr_hi_q     <= wr_hi_d;
         rd_lat_q    <= rd_lat_d;
         io_out_q    <= io_out_d;
         io_oe_q     <= io_oe_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cmd_err_q   <= cmd_err_d;
`ifdef QSPI_TARGET_STATUS_EN
         wr_sticky_q  <= wr_sticky_d;
         err_sticky_q <= err_sticky_d;
         stat_idx_q   <= stat_idx_d;
`endif
      end
   end

   assign io_out    = io_out_q;
   assign io_oe     = io_oe_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_qspi_target.sv
// Scoreboard bench for qspi_target: a bit-banged QSPI controller drives random transactions,
// a byte-level reference memory predicts responses, and a monitor checks them as they appear.
module tb_qspi_target;

   localparam int unsigned ADDR_W = 24;
   localparam int unsigned DUMMY  = 8;
   localparam int unsigned SYNC   = 2;
   localparam int unsigned HALF   = 6;

   logic              h_clk = 1'b0;
   logic              h_rstn = 1'b0;
   logic              sclk_in = 1'b0;
   logic              cs_n_in = 1'b1;
   logic [3:0]        io_in = '0;
   logic [3:0]        io_out, io_oe;
   logic              mem_req, mem_we, cmd_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata = '0;

   qspi_target #(.ADDR_W(ADDR_W), .DUMMY_CYC(DUMMY), .SYNC_STAGES(SYNC)) dut (
      .h_clk(h_clk), .h_rstn(h_rstn), .sclk_in(sclk_in), .cs_n_in(cs_n_in), .io_in(io_in),
      .io_out(io_out), .io_oe(io_oe), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cmd_err(cmd_err));

   always #5 h_clk = ~h_clk;

   int checks = 0;
   int failures = 0;

   typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [7:0] wdata; } mreq_t;
   typedef struct { logic [3:0] oe; logic [3:0] val; logic [3:0] mask; } nib_t;
   mreq_t exp_mem_q[$];
   nib_t  exp_nib_q[$];
   int    exp_err = 0;
   logic  ref_wr_sticky = 1'b0;
   logic  ref_err_sticky = 1'b0;

   logic [7:0] env_mem [logic [ADDR_W-1:0]];
   logic [7:0] ref_mem [logic [ADDR_W-1:0]];

   function automatic logic [7:0] env_rd(input logic [ADDR_W-1:0] a);
      return env_mem.exists(a) ? env_mem[a] : 8'h00;
   endfunction
   function automatic logic [7:0] ref_rd(input logic [ADDR_W-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Synchronous memory: read data valid one h_clk after the request.
   always @(posedge h_clk) begin
      if (mem_req && !mem_we) mem_rdata <= env_rd(mem_addr);
      if (mem_req && mem_we) env_mem[mem_addr] = mem_wdata;
   end

   logic  sclk_prev = 1'b0;
   logic  req_prev = 1'b0;
   mreq_t mon_m;
   nib_t  mon_n;
   always @(negedge h_clk) begin
      if (h_rstn) begin
         if (mem_req) begin
            check("mem_req_gap", 32'(req_prev), 32'd0);
            if (exp_mem_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL mem_req_unexpected actual we=%0b addr=%h required none", mem_we, mem_addr);
            end else begin
               mon_m = exp_mem_q.pop_front();
               check("mem_we", 32'(mem_we), 32'(mon_m.we));
               check("mem_addr", 32'(mem_addr), 32'(mon_m.addr));
               if (mon_m.we) check("mem_wdata", 32'(mem_wdata), 32'(mon_m.wdata));
            end
         end
         if (cmd_err) begin
            check("cmd_err_expected", 32'(exp_err > 0), 32'd1);
            if (exp_err > 0) exp_err--;
         end
         if (sclk_in && !sclk_prev && exp_nib_q.size() > 0) begin
            mon_n = exp_nib_q.pop_front();
            check("io_oe_data", 32'(io_oe), 32'(mon_n.oe));
            check("io_out_data", 32'(io_out & mon_n.mask), 32'(mon_n.val & mon_n.mask));
         end
      end
      sclk_prev = sclk_in;
      req_prev  = mem_req;
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge h_clk);
      #1;
   endtask

   task automatic sclk_cycle(input logic [3:0] io);
      sclk_in = 1'b0;
      io_in   = io;
      tick(HALF);
      sclk_in = 1'b1;
      tick(HALF);
   endtask

   task automatic send_bits(input logic [31:0] v, input int unsigned n);
      for (int i = int'(n) - 1; i >= 0; i--) sclk_cycle({3'($urandom), v[i]});
   endtask

   task automatic cs_begin();
      sclk_in = 1'b0;
      cs_n_in = 1'b0;
      tick(HALF);
   endtask

   task automatic cs_end();
      tick(2);
      cs_n_in = 1'b1;
      tick(SYNC + 2);
      check("io_oe_after_cs", 32'(io_oe), 32'd0);
      sclk_in = 1'b0;
      tick(HALF);
   endtask

   task automatic write_txn(input logic [ADDR_W-1:0] a, input int unsigned n);
      logic [7:0] b;
      cs_begin();
      send_bits(32'h32, 8);
      send_bits(32'(a), ADDR_W);
      for (int unsigned i = 0; i < n; i++) begin
         b = 8'($urandom);
         exp_mem_q.push_back('{we: 1'b1, addr: a + ADDR_W'(i), wdata: b});
         ref_mem[a + ADDR_W'(i)] = b;
         sclk_cycle(b[7:4]);
         sclk_cycle(b[3:0]);
      end
      if (n > 0) ref_wr_sticky = 1'b1;
      check("io_oe_during_write", 32'(io_oe), 32'd0);
      cs_end();
   endtask

   task automatic read_txn(input logic [ADDR_W-1:0] a, input int unsigned n);
      logic [7:0] b;
      cs_begin();
      send_bits(32'h6B, 8);
      send_bits(32'(a), ADDR_W);
      for (int unsigned d = 0; d < DUMMY; d++) begin
         if (d == DUMMY - 1) exp_mem_q.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
         sclk_cycle(4'($urandom));
      end
      for (int unsigned i = 0; i < n; i++) begin
         b = ref_rd(a + ADDR_W'(i));
         exp_nib_q.push_back('{oe: 4'hF, val: b[7:4], mask: 4'hF});
         sclk_cycle(4'($urandom));
         exp_nib_q.push_back('{oe: 4'hF, val: b[3:0], mask: 4'hF});
         exp_mem_q.push_back('{we: 1'b0, addr: a + ADDR_W'(i + 1), wdata: 8'h00});
         sclk_cycle(4'($urandom));
      end
      cs_end();
   endtask

   task automatic bad_op_txn(input logic [7:0] op);
      cs_begin();
      exp_err++;
      ref_err_sticky = 1'b1;
      send_bits(32'(op), 8);
      for (int unsigned k = 0; k < 6; k++) sclk_cycle(4'($urandom));
      check("io_oe_ignore", 32'(io_oe), 32'd0);
      cs_end();
   endtask

   task automatic status_txn(input int unsigned nbits);
      logic [7:0] s;
      s = {6'b0, ref_err_sticky, ref_wr_sticky};
      cs_begin();
      send_bits(32'h05, 8);
      for (int unsigned k = 0; k < nbits; k++) begin
         exp_nib_q.push_back('{oe: 4'b0010, val: {2'b00, s[7 - (k % 8)], 1'b0}, mask: 4'b0010});
         sclk_cycle(4'($urandom));
      end
      cs_end();
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] v);
      env_mem[a] = v;
      ref_mem[a] = v;
   endtask

   function automatic logic [7:0] rand_bad_op();
      logic [7:0] op;
      do op = 8'($urandom);
`ifdef QSPI_TARGET_STATUS_EN
      while (op == 8'h6B || op == 8'h32 || op == 8'h05);
`else
      while (op == 8'h6B || op == 8'h32);
`endif
      return op;
   endfunction

   initial begin
      #(800_000);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [ADDR_W-1:0] last_wr;
   logic [ADDR_W-1:0] ra;
   int unsigned       len;

   initial begin
      last_wr = '0;
      tick(3);
      check("rst_io_out", 32'(io_out), 32'd0);
      check("rst_io_oe", 32'(io_oe), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst_cmd_err", 32'(cmd_err), 32'd0);
      h_rstn = 1'b1;
      tick(HALF);

`ifdef QSPI_TARGET_STATUS_EN
      write_txn(24'h000040, 1);
      status_txn(10);
      bad_op_txn(8'hC7);
      status_txn(16);
`else
      bad_op_txn(8'h05);
`endif

      write_txn(24'h000010, 2);
      preload(24'h000010, 8'h5A);
      preload(24'h000011, 8'hC3);
      read_txn(24'h000010, 2);

      preload(24'hFFFFFF, 8'($urandom));
      preload(24'h000000, 8'($urandom));
      read_txn(24'hFFFFFF, 2);

      bad_op_txn(8'h9F);
      write_txn(24'h000020, 2);
      read_txn(24'h000020, 2);

      // Aborted write after one nibble, then aborted address phase.
      cs_begin();
      send_bits(32'h32, 8);
      send_bits(32'h000030, ADDR_W);
      sclk_cycle(4'hE);
      cs_end();
      cs_begin();
      send_bits(32'h32, 8);
      send_bits(32'h000003, 12);
      cs_end();
      write_txn(24'h000030, 1);
      read_txn(24'h000030, 1);

      for (int unsigned it = 0; it < 12; it++) begin
         len = $urandom_range(1, 3);
         case ($urandom_range(0, 3))
            0: begin
               last_wr = ADDR_W'($urandom);
               write_txn(last_wr, len);
            end
            1: read_txn(last_wr, len);
            2: read_txn(ADDR_W'($urandom), len);
            default: bad_op_txn(rand_bad_op());
         endcase
      end

      tick(4);
      check("drain_mem_q", 32'(exp_mem_q.size()), 32'd0);
      check("drain_nib_q", 32'(exp_nib_q.size()), 32'd0);
      check("drain_cmd_err", 32'(exp_err), 32'd0);

      // Asynchronous reset in the middle of a read data phase.
      ra = 24'h123456;
      preload(ra, 8'hE7);
      cs_begin();
      send_bits(32'h6B, 8);
      send_bits(32'(ra), ADDR_W);
      for (int unsigned d = 0; d < DUMMY; d++) begin
         if (d == DUMMY - 1) exp_mem_q.push_back('{we: 1'b0, addr: ra, wdata: 8'h00});
         sclk_cycle(4'h0);
      end
      exp_nib_q.push_back('{oe: 4'hF, val: 4'hE, mask: 4'hF});
      sclk_cycle(4'h0);
      check("pre_rst_io_oe", 32'(io_oe), 32'hF);
      check("pre_rst_mem_addr", 32'(mem_addr), 32'(ra));
      h_rstn = 1'b0;
      #1;
      check("mid_rst_io_out", 32'(io_out), 32'd0);
      check("mid_rst_io_oe", 32'(io_oe), 32'd0);
      check("mid_rst_mem_req", 32'(mem_req), 32'd0);
      check("mid_rst_mem_we", 32'(mem_we), 32'd0);
      check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
      check("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
      check("mid_rst_cmd_err", 32'(cmd_err), 32'd0);
      cs_n_in = 1'b1;
      sclk_in = 1'b0;
      tick(3);
      exp_mem_q.delete();
      exp_nib_q.delete();
      exp_err = 0;
      ref_wr_sticky = 1'b0;
      ref_err_sticky = 1'b0;
      h_rstn = 1'b1;
      tick(HALF);
      read_txn(24'h000010, 1);
      tick(4);
      check("final_mem_q", 32'(exp_mem_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qspi_target.md
Name: qspi_target

Overview:
- Synthesizable QSPI responder (target) that serves as the far end of the controller's SCLK/CS_n/IO bus.
- Used as the on-chip loopback target and as the DUT partner in controller system tests.
- Oversamples sclk_in, cs_n_in and io_in in the h_clk domain, decodes single-line command and address phases, and serves quad-width data from a 1-cycle-latency byte memory port.
- Supports SPI mode 0 only: samples on SCLK rise, drives on SCLK fall.

Parameters:
- ADDR_W, 24: byte address width; address counter wraps modulo 2^ADDR_W.
- DUMMY_CYC, 8: SCLK cycles between the last address bit and the first read data nibble.
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers (minimum 2).

Ports:
- h_clk  in  1  system clock
- h_rstn  in  1  asynchronous, active-low reset
- sclk_in  in  1  SPI clock from controller; must satisfy f(sclk) ≤ f(h_clk)/8
- cs_n_in  in  1  chip select, active low
- io_in  in  4  IO[3:0] input
- io_out  out  4  IO[3:0] drive value
- io_oe  out  4  per-line output enable
- mem_req  out  1  one-cycle memory access strobe
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid exactly 1 h_clk after a read mem_req
- cmd_err  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset values: io_out=0, io_oe=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cmd_err=0; FSM in IDLE; synchronizer flops: sclk 0, cs_n 1, io 0.
- sclk_in, cs_n_in and io_in each pass through SYNC_STAGES flops.
- sclk rise/fall are single-cycle pulses derived from the synced value and its one-cycle delay.
- All FSM activity occurs only on detected edges. io_in is sampled together with the synced sclk, so both have equal latency.
- FSM states: IDLE → CMD → ADDR → {DUMMY → RD_DATA | WR_DATA}, plus IGNORE.
- IDLE: on synced cs_n falling, clear bit counter and enter CMD.
- CMD: shift io_in[0] MSB-first on 8 rises. The opcode is decided on the 8th rise:
  - 0x6B (quad output read) → ADDR.
  - 0x32 (quad write) → ADDR.
  - Any other opcode → pulse cmd_err, enter IGNORE.
- ADDR: shift io_in[0] MSB-first on ADDR_W rises, then load the address counter.
  - Read: go to DUMMY.
  - Write: go to WR_DATA.
- DUMMY: count DUMMY_CYC rises.
  - On the final rise, issue a read mem_req at the address counter.
  - Latch mem_rdata the next cycle into the tx byte; enter RD_DATA.
- RD_DATA:
  - On each fall, drive a nibble on io_out[3:0], high nibble first, io_out[3] = nibble MSB; io_oe=4'hF from the first fall onward.
  - After the low nibble is driven, increment the address (wrap at 2^ADDR_W) and issue the next read.
  - The next byte is latched before the following fall.
- WR_DATA: on each rise, capture io_in[3:0], high nibble first.
  - On the 2nd nibble, pulse mem_req=1, mem_we=1, mem_wdata=byte at the current address, then increment the address with wrap.
- IGNORE: no outputs and no mem_req until cs_n rises.
- Synced cs_n rising in any state:
  - Next cycle: FSM → IDLE, io_oe=0, counters cleared.
  - A partial write byte is discarded.
  - A read issued this cycle completes, but its data is dropped.
- SCLK edges while cs_n is high are ignored.
- h_rstn assertion mid-transfer: all outputs return to reset values immediately.
- mem_req never asserts on two consecutive cycles.

Optional Feature:
- Macro: QSPI_TARGET_STATUS_EN.
- Defined:
  - Opcode 0x05 (read status) is accepted and proceeds straight from CMD to a STATUS state.
  - The status byte {6'b0, err_sticky, wr_sticky} is driven MSB-first on io_out[1] with io_oe=4'b0010, one bit per fall, repeating until cs_n rises.
  - wr_sticky sets on any write mem_req; err_sticky sets on any cmd_err.
  - Both sticky bits clear on reset only.
- Undefined: 0x05 is an unsupported opcode, and no sticky registers exist.

Decomposition:
- qspi_target_pkg holds:
  - The state enum (IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE, STATUS).
  - Opcode constants OP_QREAD=8'h6B, OP_QWRITE=8'h32, OP_RDSR=8'h05.
  - The nibble-count constant.
- One sub-module, qspi_sync_edge: a SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated for sclk_in and cs_n_in. io_in uses a plain synchronizer.

Test Plan:
- Controller at clk_div=3 sends 0x32, addr 0x000010, bytes A5 3C → two write mem_req at 0x10/0x11 with data A5/3C; io_oe stays 0.
- Memory preloaded with 0x10=0x5A, 0x11=0xC3; send 0x6B, addr 0x000010, 8 dummy clocks, read 2 bytes → nibbles 5,A,C,3 on io_out; io_oe=F; reads at 0x10, 0x11.
- Send 0x6B at addr 0xFFFFFF, read 2 bytes → mem_addr sequence FFFFFF then 000000.
- Send opcode 0x9F → single cmd_err pulse; no mem_req, io_oe=0 until cs_n rises; a following 0x32 transaction succeeds.
- Raise cs_n after 1 write nibble, and separately mid-address → no write mem_req; FSM back in IDLE; io_oe=0 within SYNC_STAGES+2 cycles.
- With QSPI_TARGET_STATUS_EN defined: do a write, then 0x05 → io_out[1] carries 0x01 MSB-first; after a bad opcode, 0x05 → 0x03.
